// File: rtl/pipe_mux_reg.sv
// rtl/pipe_mux_reg.sv - N-way WIDTH-bit selector with registered output, stall/flush and valid.
// Optional sticky illegal-select flag enabled by macro PIPE_MUX_SEL_CHECK_EN.
module pipe_mux_reg #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   input  logic                    stall,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   output logic                    sel_err
);

   generate
      if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
         $error("pipe_mux_reg: NUM_IN=%0d outside legal range 2..16", NUM_IN);
      end
   endgenerate

   logic [WIDTH-1:0] mux_data;
   logic             capture;

   // Selects with no matching input (sel >= NUM_IN) fall through to zero.
   always_comb begin
      mux_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) mux_data = in_data[k*WIDTH +: WIDTH];
      end
   end

   assign capture = !flush && !stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (flush) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (!stall) begin
         out_data  <= mux_data;
         out_valid <= in_valid;
      end
   end

`ifdef PIPE_MUX_SEL_CHECK_EN
   logic sel_illegal;

   assign sel_illegal = (int'(sel) >= NUM_IN);

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_err <= 1'b0;
      end else if (capture && in_valid && sel_illegal) begin
         sel_err <= 1'b1;
`ifndef SYNTHESIS
         $error("pipe_mux_reg: illegal select at %0t, sel=%0d", $time, sel);
`endif
      end
   end
`else
   assign sel_err = 1'b0;
`endif

endmodule
